// File: rtl/alu_pkg.sv
// Shared types and constants for the pipelined saturating add/sub unit.
// Latency: n/a (types, constants and constant-folded helpers only).
// Backpressure: n/a.
package alu_pkg;

    // Widest operand any instance may use. Records are sized to this, and synthesis trims the unused upper bits.
    localparam int unsigned ALU_MAX_W = 64;

    typedef logic [ALU_MAX_W-1:0] alu_word_t;

    // One pipeline stage's worth of in-flight state.
    // a_hi/b_hi carry the operands so later stages can read their upper segments.
    // sum_lo gathers the result segments already resolved.
    // carry is the carry into the next segment to be resolved.
    typedef struct packed {
        logic      valid;
        logic      sub;
        alu_word_t a_hi;
        alu_word_t b_hi;
        alu_word_t sum_lo;
        logic      carry;
        logic      a_msb;
    } pipe_rec_t;

    // Most negative two's-complement value of width w (1 << (w-1)).
    function automatic alu_word_t sat_min(input int unsigned w);
        return alu_word_t'(1) << (w - 1);
    endfunction

    // Most positive two's-complement value of width w.
    function automatic alu_word_t sat_max(input int unsigned w);
        return sat_min(w) - alu_word_t'(1);
    endfunction

endpackage

// File: rtl/addsub_seg.sv
// SEG-bit ripple add/sub slice: sum = a + (b ^ {SEG{sub}}) + cin.
// Latency: combinational.
// Backpressure: none. The enclosing pipeline registers its outputs.
module addsub_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           sub,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb_in
);

    logic [SEG:0]   c;
    logic [SEG-1:0] b_eff;

    // Subtraction is A + ~B + 1. The +1 arrives as the stage-0 carry-in.
    assign b_eff = b ^ {SEG{sub}};
    assign c[0]  = cin;

    for (genvar i = 0; i < SEG; i++) begin : g_fa
        full_adder_1bit u_fa (
            .a   (a[i]),
            .b   (b_eff[i]),
            .cin (c[i]),
            .sum (sum[i]),
            .cout(c[i+1])
        );
    end

    assign cout     = c[SEG];
    // The carry into the top bit feeds the signed-overflow check in the last segment.
    assign c_msb_in = c[SEG-1];

endmodule

// File: rtl/full_adder_1bit.sv
// Single-bit full adder, the ripple cell used by each segment adder.
// Latency: combinational.
// Backpressure: none (pure function of inputs).
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/addsub_sat_pipe.sv
// Pipelined saturating signed add/sub, resolving SEG bits per stage with a registered carry between stages.
// Latency: WIDTH/SEG cycles from accept to out_valid. Throughput is one op per cycle.
// Backpressure: out_valid & ~out_ready freezes every stage and drops in_ready. Nothing is lost or duplicated.
module addsub_sat_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int SEG    = 4,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovfl,
    output logic             neg,
    output logic             zero
);

    localparam int NSEG = WIDTH / SEG;
    // Register slots between stages. Kept at least one wide so the array is always legal.
    localparam int NREG = (NSEG > 1) ? NSEG - 1 : 1;

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));

    if (SEG < 1) begin : g_bad_seg
        $error("addsub_sat_pipe: SEG must be >= 1");
    end
    else if ((WIDTH % SEG) != 0) begin : g_bad_split
        $error("addsub_sat_pipe: WIDTH must be a multiple of SEG");
    end
    if (WIDTH > ALU_MAX_W) begin : g_too_wide
        $error("addsub_sat_pipe: WIDTH exceeds ALU_MAX_W");
    end

    logic             stall;
    logic             en;
    pipe_rec_t        head;
    pipe_rec_t        cur     [NSEG];
    pipe_rec_t        nxt     [NSEG];
    pipe_rec_t        stage_q [NREG];
    logic [SEG-1:0]   seg_sum [NSEG];
    logic             seg_cout[NSEG];
    logic             seg_cmsb[NSEG];
    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] fin_res;
    logic             fin_v;

    // A single global enable: either everything advances or everything holds.
    assign stall    = out_valid & ~out_ready;
    assign en       = ~stall;
    assign in_ready = en;

    // Package the incoming operands as the stage-0 record. For subtraction the carry-in starts at 1.
    always_comb begin
        head        = '0;
        head.valid  = in_valid;
        head.sub    = sub;
        head.a_hi   = ALU_MAX_W'(a);
        head.b_hi   = ALU_MAX_W'(b);
        head.carry  = sub;
        head.a_msb  = a[WIDTH-1];
    end

    // Stage k works on the head record (k=0) or on what stage k-1 registered last cycle.
    always_comb begin
        cur[0] = head;
        for (int k = 1; k < NSEG; k++) begin
            cur[k] = stage_q[k-1];
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        addsub_seg #(.SEG(SEG)) u_seg (
            .a       (cur[k].a_hi[k*SEG +: SEG]),
            .b       (cur[k].b_hi[k*SEG +: SEG]),
            .sub     (cur[k].sub),
            .cin     (cur[k].carry),
            .sum     (seg_sum[k]),
            .cout    (seg_cout[k]),
            .c_msb_in(seg_cmsb[k])
        );
    end

    // Merge each stage's freshly resolved segment and carry-out into the record it hands forward.
    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            nxt[k]                        = cur[k];
            nxt[k].sum_lo[k*SEG +: SEG]   = seg_sum[k];
            nxt[k].carry                  = seg_cout[k];
        end
    end

    // Inter-stage registers. They advance only when the output is not back-pressured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREG; k++) begin
                stage_q[k] <= '0;
            end
        end
        else if (en) begin
            for (int k = 0; k < NSEG - 1; k++) begin
                stage_q[k] <= nxt[k];
            end
        end
    end

    // Last stage: signed overflow from the carries around the MSB, then clamp toward A's sign.
    always_comb begin
        raw_sum = nxt[NSEG-1].sum_lo[WIDTH-1:0];
        fin_v   = seg_cmsb[NSEG-1] ^ seg_cout[NSEG-1];
        fin_res = raw_sum;
        if (SAT_EN && fin_v) begin
            fin_res = cur[NSEG-1].a_msb ? MIN_V : MAX_V;
        end
    end

    // Output register. Data only updates for real ops, so bubbles leave the last result visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            ovfl      <= 1'b0;
            neg       <= 1'b0;
            zero      <= 1'b1;
        end
        else if (en) begin
            out_valid <= cur[NSEG-1].valid;
            if (cur[NSEG-1].valid) begin
                result <= fin_res;
                ovfl   <= fin_v;
                neg    <= fin_res[WIDTH-1];
                zero   <= (fin_res == '0);
            end
        end
    end

endmodule

// File: tb/tb_addsub_sat_pipe.sv
// Bench for addsub_sat_pipe, driving a saturating and a wrapping instance with the same operand stream.
// Latency: expects 4 cycles (WIDTH=16, SEG=4) from accept to result.
// Backpressure: exercises out_ready stalls and checks hold and ordering.
module tb_addsub_sat_pipe;

    typedef struct packed {
        logic [15:0] res;
        logic        v;
        logic        n;
        logic        z;
    } exp_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        exp_t        e;
        exp_t        we;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        ovfl;
    logic        neg;
    logic        zero;
    logic        w_in_ready;
    logic        w_out_valid;
    logic [15:0] w_result;
    logic        w_ovfl;
    logic        w_neg;
    logic        w_zero;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];
    exp_t wexp_q[$];
    exp_t exp_next, wexp_next, exp_pop, wexp_pop, obs, wobs;
    logic acc, fire, stray, w_sync, obs_in_ready, obs_w_in_ready, obs_out_valid;

    addsub_sat_pipe #(.WIDTH(16), .SEG(4), .SAT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ovfl(ovfl), .neg(neg), .zero(zero)
    );

    addsub_sat_pipe #(.WIDTH(16), .SEG(4), .SAT_EN(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(w_out_valid), .out_ready(out_ready),
        .result(w_result), .ovfl(w_ovfl), .neg(w_neg), .zero(w_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: 17-bit signed arithmetic, overflow when the two top bits disagree.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic s, input logic sat);
        logic [16:0] f;
        exp_t e;
        f = s ? ({x[15], x} - {y[15], y}) : ({x[15], x} + {y[15], y});
        e.v   = f[16] ^ f[15];
        e.res = f[15:0];
        if (sat && e.v) e.res = x[15] ? 16'h8000 : 16'h7FFF;
        e.n = e.res[15];
        e.z = (e.res == 16'h0000);
        return e;
    endfunction

    function automatic exp_t mk(input logic [15:0] r, input logic v, input logic n, input logic z);
        exp_t e;
        e.res = r; e.v = v; e.n = n; e.z = z;
        return e;
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'h0000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic set_rand_op();
        a = rnd16();
        b = rnd16();
        sub = 1'($urandom_range(0, 1));
        exp_next  = model(a, b, sub, 1'b1);
        wexp_next = model(a, b, sub, 1'b0);
    endtask

    // Advance one cycle: sample at negedge, update the scoreboard, return just after the next posedge.
    task automatic tick();
        @(negedge clk);
        acc            = in_valid && in_ready;
        fire           = out_valid && out_ready;
        obs_in_ready   = in_ready;
        obs_w_in_ready = w_in_ready;
        obs_out_valid  = out_valid;
        obs            = {result, ovfl, neg, zero};
        wobs           = {w_result, w_ovfl, w_neg, w_zero};
        w_sync         = (w_out_valid === out_valid);
        stray          = 1'b0;
        if (fire) begin
            if (exp_q.size() > 0) begin
                exp_pop  = exp_q.pop_front();
                wexp_pop = wexp_q.pop_front();
            end
            else begin
                stray    = 1'b1;
                exp_pop  = '0;
                wexp_pop = '0;
            end
        end
        if (acc) begin
            exp_q.push_back(exp_next);
            wexp_q.push_back(wexp_next);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, result, ovfl, neg, zero} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got v=%b r=%h o=%b n=%b z=%b want v=0 r=0000 o=0 n=0 z=1",
                     out_valid, result, ovfl, neg, zero);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || w_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b/%b want 1/1", in_ready, w_in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_rand_op();
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (exp_q.size() != 3) begin
            errors++;
            $display("FAIL reset_inflight: got %0d accepted want 3", exp_q.size());
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || zero !== 1'b1 || w_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_midstream: got v=%b z=%b wv=%b want v=0 z=1 wv=0", out_valid, zero, w_out_valid);
        end
        exp_q.delete();
        wexp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (fire || !w_sync) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_stale: got %0d stale outputs want 0", seen);
        end
    endtask

    task automatic test_basic();
        vec_t v[2];
        int lat;
        v[0] = {16'h1234, 16'h0FED, 1'b0, mk(16'h2221, 1'b0, 1'b0, 1'b0), mk(16'h2221, 1'b0, 1'b0, 1'b0)};
        v[1] = {16'h0005, 16'h0007, 1'b1, mk(16'hFFFE, 1'b0, 1'b1, 1'b0), mk(16'hFFFE, 1'b0, 1'b1, 1'b0)};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a = v[i].a; b = v[i].b; sub = v[i].s;
            exp_next = v[i].e; wexp_next = v[i].we;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            checks++;
            if (acc !== 1'b1) begin
                errors++;
                $display("FAIL basic_accept[%0d]: got %b want 1", i, acc);
            end
            lat = 0;
            fire = 1'b0;
            while (!fire && lat < 20) begin
                tick();
                lat++;
            end
            checks++;
            if (lat != 4) begin
                errors++;
                $display("FAIL basic_latency[%0d]: got %0d want 4", i, lat);
            end
            checks++;
            if (stray || !w_sync || obs !== v[i].e || wobs !== v[i].we) begin
                errors++;
                $display("FAIL basic_result[%0d]: got %h/%h want %h/%h", i, obs, wobs, v[i].e, v[i].we);
            end
        end
    endtask

    task automatic test_saturation();
        vec_t v[6];
        int sent, got, t;
        v[0] = {16'h7FFF, 16'h0001, 1'b0, mk(16'h7FFF, 1'b1, 1'b0, 1'b0), mk(16'h8000, 1'b1, 1'b1, 1'b0)};
        v[1] = {16'h8000, 16'h0001, 1'b1, mk(16'h8000, 1'b1, 1'b1, 1'b0), mk(16'h7FFF, 1'b1, 1'b0, 1'b0)};
        v[2] = {16'h0000, 16'h8000, 1'b1, mk(16'h7FFF, 1'b1, 1'b0, 1'b0), mk(16'h8000, 1'b1, 1'b1, 1'b0)};
        v[3] = {16'h8000, 16'h8000, 1'b1, mk(16'h0000, 1'b0, 1'b0, 1'b1), mk(16'h0000, 1'b0, 1'b0, 1'b1)};
        v[4] = {16'h8000, 16'h8000, 1'b0, mk(16'h8000, 1'b1, 1'b1, 1'b0), mk(16'h0000, 1'b1, 1'b0, 1'b1)};
        v[5] = {16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b0, 1'b0, 1'b1), mk(16'h0000, 1'b0, 1'b0, 1'b1)};
        out_ready = 1'b1;
        sent = 0; got = 0; t = 0;
        in_valid = 1'b1;
        a = v[0].a; b = v[0].b; sub = v[0].s; exp_next = v[0].e; wexp_next = v[0].we;
        while ((sent < 6 || got < 6) && t < 100) begin
            tick();
            if (acc) begin
                sent++;
                if (sent < 6) begin
                    a = v[sent].a; b = v[sent].b; sub = v[sent].s;
                    exp_next = v[sent].e; wexp_next = v[sent].we;
                end
                else in_valid = 1'b0;
            end
            if (fire) begin
                got++;
                checks++;
                if (stray || !w_sync || obs !== exp_pop || wobs !== wexp_pop) begin
                    errors++;
                    $display("FAIL saturate[%0d]: got %h/%h want %h/%h", got - 1, obs, wobs, exp_pop, wexp_pop);
                end
            end
            t++;
        end
        checks++;
        if (got != 6) begin
            errors++;
            $display("FAIL saturate_count: got %0d want 6", got);
        end
    endtask

    task automatic test_back_to_back();
        int sent, got, t, first, last;
        out_ready = 1'b1;
        sent = 0; got = 0; t = 0; first = -1; last = -1;
        in_valid = 1'b1;
        set_rand_op();
        while ((sent < 20 || got < 20) && t < 200) begin
            tick();
            if (acc) begin
                sent++;
                if (sent < 20) set_rand_op();
                else in_valid = 1'b0;
            end
            if (fire) begin
                got++;
                if (first < 0) first = t;
                last = t;
                checks++;
                if (stray || !w_sync || obs !== exp_pop || wobs !== wexp_pop) begin
                    errors++;
                    $display("FAIL b2b[%0d]: got %h/%h want %h/%h", got - 1, obs, wobs, exp_pop, wexp_pop);
                end
            end
            t++;
        end
        checks++;
        if (sent != 20 || got != 20) begin
            errors++;
            $display("FAIL b2b_count: got sent=%0d out=%0d want 20/20", sent, got);
        end
        checks++;
        if (last - first != 19) begin
            errors++;
            $display("FAIL b2b_rate: got span %0d want 19", last - first);
        end
    endtask

    task automatic test_backpressure();
        int sent, got, t, st;
        sent = 0; got = 0; t = 0; st = 0;
        in_valid = 1'b1;
        set_rand_op();
        while ((sent < 15 || got < 15) && t < 200) begin
            out_ready = (got >= 3 && st < 5) ? 1'b0 : 1'b1;
            tick();
            if (!out_ready) begin
                st++;
                checks++;
                if (obs_in_ready !== 1'b0 || obs_w_in_ready !== 1'b0 || obs_out_valid !== 1'b1 ||
                    exp_q.size() == 0 || obs !== exp_q[0]) begin
                    errors++;
                    $display("FAIL stall_hold[%0d]: got rdy=%b/%b vld=%b res=%h want rdy=0/0 vld=1 res=%h",
                             st, obs_in_ready, obs_w_in_ready, obs_out_valid, obs,
                             (exp_q.size() > 0) ? exp_q[0] : exp_t'('0));
                end
            end
            if (acc) begin
                sent++;
                if (sent < 15) set_rand_op();
                else in_valid = 1'b0;
            end
            if (fire) begin
                got++;
                checks++;
                if (stray || !w_sync || obs !== exp_pop || wobs !== wexp_pop) begin
                    errors++;
                    $display("FAIL bp[%0d]: got %h/%h want %h/%h", got - 1, obs, wobs, exp_pop, wexp_pop);
                end
            end
            t++;
        end
        out_ready = 1'b1;
        checks++;
        if (sent != 15 || got != 15 || st != 5 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_count: got sent=%0d out=%0d stalls=%0d left=%0d want 15/15/5/0",
                     sent, got, st, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_back_to_back();
        test_backpressure();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
